// File: rtl/data_line_memory_pkg.sv
// Shared widths and FSM encodings for the line memory model; the state
// encodings are also decoded by external cache bench monitors.
package data_line_memory_pkg;
   localparam int LINE_W     = 256;
   localparam int ADDR_W     = 32;
   localparam int LINE_OFS_W = 5;
   localparam int CNT_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;
endpackage

// File: rtl/data_line_memory_latency_counter.sv
// Access latency counter: load starts a count at 1, inc advances it, done
// flags the cycle where the count has reached LATENCY.
module data_line_memory_latency_counter
   import data_line_memory_pkg::*;
#(
   parameter int unsigned LATENCY = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(1);
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   // inc is only asserted while !done, so the count stops at LATENCY and never wraps
   assign done = (count == CNT_W'(LATENCY));

endmodule

// File: rtl/data_line_memory.sv
// Off-chip line memory model: one 256-bit read or write per request, acked
// with a single-cycle pulse a fixed LATENCY cycles after acceptance.
module data_line_memory
   import data_line_memory_pkg::*;
#(
   parameter int unsigned LATENCY = 10,
   parameter int unsigned DEPTH   = 512
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic              busy_o,
   output logic [1:0]        state_o
);

   localparam int IDX_W = $clog2(DEPTH);

   // Handshake: a request is taken when enable_i is high on an edge in IDLE;
   // ack_o pulses for one cycle on completion, and enable_i must be dropped
   // in that ack cycle or the following IDLE edge starts a new request.
   state_t              state;
   logic                req_write;
   logic [IDX_W-1:0]    req_idx;
   logic [LINE_W-1:0]   req_data;
   logic [LINE_W-1:0]   mem [0:DEPTH-1];
   logic [CNT_W-1:0]    count;
   logic                done;
   logic                accept;
   logic                finish;
   logic                unused_addr_bits;

   assign accept  = (state == ST_IDLE) && enable_i;
   assign finish  = (state == ST_WAIT) && done;
   assign state_o = state;
   assign unused_addr_bits = ^{addr_i[ADDR_W-1:LINE_OFS_W+IDX_W], addr_i[LINE_OFS_W-1:0]};

   data_line_memory_latency_counter #(.LATENCY(LATENCY)) u_counter (
      .clk   (clk_i),
      .rst   (rst_i),
      .load  (accept),
      .inc   ((state == ST_WAIT) && !done),
      .count (count),
      .done  (done)
   );

   // Every request passes through WAIT, so LATENCY=1 still spans acceptance,
   // one WAIT cycle and the ack cycle (one request per three edges).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         ack_o     <= 1'b0;
         busy_o    <= 1'b0;
         data_o    <= '0;
         req_write <= 1'b0;
         req_idx   <= '0;
         req_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               ack_o <= 1'b0;
               if (enable_i) begin
                  req_write <= write_i;
                  req_idx   <= addr_i[LINE_OFS_W +: IDX_W];
                  req_data  <= data_i;
                  busy_o    <= 1'b1;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (done) begin
                  ack_o <= 1'b1;
                  state <= ST_ACK;
                  if (!req_write) begin
                     data_o <= mem[req_idx];
                  end
               end
            end
            ST_ACK: begin
               ack_o  <= 1'b0;
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               ack_o  <= 1'b0;
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   // Array is deliberately left unreset; a reset mid-WAIT leaves state IDLE so the write is dropped.
   always_ff @(posedge clk_i) begin
      if (finish && req_write) begin
         mem[req_idx] <= req_data;
      end
   end

   logic [CNT_W-1:0] unused_count;
   assign unused_count = count;

endmodule

// File: tb/tb_data_line_memory.sv
// Directed bench for data_line_memory: LATENCY=10/DEPTH=512 instance for
// data/timing/aliasing checks, LATENCY=1 instance for back-to-back timing.
module tb_data_line_memory;

   logic         clk;
   logic         rst;
   logic         enable, write;
   logic [31:0]  addr;
   logic [255:0] wdata;
   logic         ack, busy;
   logic [255:0] rdata;
   logic [1:0]   state;

   logic         enable1, write1;
   logic [31:0]  addr1;
   logic [255:0] wdata1;
   logic         ack1, busy1;
   logic [255:0] rdata1;
   logic [1:0]   state1;

   int checks = 0;
   int errors = 0;

   localparam logic [255:0] V0  = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] V1  = {8{32'h1234_5678}};
   localparam logic [255:0] A5  = {32{8'hA5}};
   localparam logic [255:0] ONE = 256'h1;
   localparam logic [255:0] AL  = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [255:0] W2  = {16{16'h5A3C}};

   data_line_memory #(.LATENCY(10), .DEPTH(512)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (enable),
      .write_i  (write),
      .addr_i   (addr),
      .data_i   (wdata),
      .ack_o    (ack),
      .data_o   (rdata),
      .busy_o   (busy),
      .state_o  (state)
   );

   data_line_memory #(.LATENCY(1), .DEPTH(16)) dut1 (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (enable1),
      .write_i  (write1),
      .addr_i   (addr1),
      .data_i   (wdata1),
      .ack_o    (ack1),
      .data_o   (rdata1),
      .busy_o   (busy1),
      .state_o  (state1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before 500000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for the ack cycle, then steps once more back into IDLE.
   task automatic wait_ack(input string tag);
      int n = 0;
      while (!ack && n < 50) begin
         step();
         n++;
      end
      chk(tag, ack, 1'b1);
      step();
   endtask

   task automatic txn(input logic wr, input logic [31:0] a, input logic [255:0] d, input string tag);
      enable = 1'b1;
      write  = wr;
      addr   = a;
      wdata  = d;
      step();
      enable = 1'b0;
      wait_ack(tag);
   endtask

   task automatic rd(input logic [31:0] a, input logic [255:0] exp, input string tag);
      txn(1'b0, a, '0, {tag, "_ack"});
      chk(tag, rdata, exp);
   endtask

   task automatic churn(input logic wr, input logic [31:0] a, input logic [255:0] d, input string tag);
      int n = 0;
      int acks = 0;
      enable = 1'b1;
      write  = wr;
      addr   = a;
      wdata  = d;
      step();
      while (!ack && n < 50) begin
         addr   = $urandom;
         wdata  = {8{$urandom}};
         enable = 1'($urandom_range(0, 1));
         write  = 1'($urandom_range(0, 1));
         step();
         n++;
         if (ack) acks++;
      end
      enable = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (ack) acks++;
      end
      chk({tag, "_acks"}, 256'(acks), 256'd1);
   endtask

   initial begin
      int acks;
      logic prev_ack;
      rst = 1'b1;
      enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
      enable1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
      step(); step();
      chk("rst_ack", ack, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data", rdata, '0);
      chk("rst_state", state, 2'd0);
      rst = 1'b0;
      step();

      // Reset mid-WAIT aborts a write to 0x100 with no ack
      txn(1'b1, 32'h100, V0, "w100_ack");
      enable = 1'b1; write = 1'b1; addr = 32'h100; wdata = V1;
      step();
      enable = 1'b0;
      step(); step(); step();
      chk("wait_busy", busy, 1'b1);
      chk("wait_state", state, 2'd1);
      rst = 1'b1;
      #2;
      chk("abort_busy", busy, 1'b0);
      chk("abort_ack", ack, 1'b0);
      chk("abort_state", state, 2'd0);
      step();
      rst = 1'b0;
      acks = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (ack) acks++;
      end
      chk("abort_no_ack", 256'(acks), 256'd0);
      rd(32'h100, V0, "r100_prior");

      // Read timing with LATENCY=10: accept at edge 0, ack only after edge 10
      txn(1'b1, 32'h80, A5, "w80_ack");
      enable = 1'b1; write = 1'b0; addr = 32'h80;
      step();
      enable = 1'b0;
      chk("t0_busy", busy, 1'b1);
      chk("t0_ack", ack, 1'b0);
      for (int k = 1; k <= 11; k++) begin
         step();
         chk($sformatf("t%0d_ack", k), ack, (k == 10));
         chk($sformatf("t%0d_busy", k), busy, (k <= 10));
         if (k == 10) chk("t10_data", rdata, A5);
      end
      chk("t11_data_held", rdata, A5);

      // Write then read, offset bits ignored; write leaves data_o alone
      txn(1'b1, 32'h0000_0040, ONE, "w40_ack");
      chk("write_keeps_data", rdata, A5);
      rd(32'h0000_0040, ONE, "r40");
      rd(32'h0000_005F, ONE, "r5f");

      // Aliasing: 0x4000 maps to line 0 at DEPTH=512
      txn(1'b1, 32'h0000_4000, AL, "w4000_ack");
      rd(32'h0000_0000, AL, "r0_alias");

      // Input churn during WAIT
      churn(1'b0, 32'h80, '0, "churn_rd");
      chk("churn_rd_data", rdata, A5);
      churn(1'b1, 32'h40, W2, "churn_wr");
      rd(32'h40, W2, "churn_wr_line");
      rd(32'h80, A5, "churn_other_line");
      rd(32'h100, V0, "churn_line100");

      // LATENCY=1 back-to-back with enable held high
      enable1 = 1'b1; write1 = 1'b0; addr1 = 32'h0;
      step();
      prev_ack = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk($sformatf("l1_e%0d_ack", k), ack1, ((k % 3) == 1));
         chk($sformatf("l1_e%0d_noconsec", k), prev_ack & ack1, 1'b0);
         prev_ack = ack1;
      end
      enable1 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
